// File: rtl/noc_seq_pkg.sv
// Shared definitions for the NoC sequencer: op codes, FSM states, default widths.
// NOC_SEQ_DONE_WAIT_EN adds the WAIT state used to hold on router_done.
package noc_seq_pkg;

    localparam int ROUTERS_DEF = 16;
    localparam int PORT_W_DEF  = 3;
    localparam int OP_W_DEF    = 3;
    localparam int MC_W_DEF    = 16;

    localparam int OP_NOP          = 0;
    localparam int OP_INIT         = 1;
    localparam int OP_LOAD_RT      = 2;
    localparam int OP_LOAD_STAGING = 3;
    localparam int OP_PHASE0       = 4;
    localparam int OP_PHASE1       = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_LOAD_RT = 3'd2,
        S_STAGE   = 3'd3,
        S_PH0     = 3'd4,
        S_PH1     = 3'd5,
`ifdef NOC_SEQ_DONE_WAIT_EN
        S_WAIT    = 3'd6,
`endif
        S_FINISH  = 3'd7
    } state_t;

endpackage

// File: rtl/noc_seq_rt_loader.sv
// Routing-table load path: destination counter, read address, per-router
// LOAD_RT/NOP select and the captured out-port / destination registers.
module noc_seq_rt_loader
    import noc_seq_pkg::*;
#(
    parameter int ROUTERS = ROUTERS_DEF,
    parameter int PORT_W  = PORT_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int RB_W    = $clog2(ROUTERS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_init,
    input  logic                      in_load,
    input  logic [ROUTERS*PORT_W-1:0] rt_rd_data,
    input  logic [ROUTERS-1:0]        rt_rd_vld,
    output logic [RB_W-1:0]           rt_rd_addr,
    output logic [ROUTERS*PORT_W-1:0] router_rt_port,
    output logic [RB_W-1:0]           router_rt_dst,
    output logic [ROUTERS*OP_W-1:0]   rt_ops,
    output logic                      last_dst
);

    logic capture;

    assign last_dst = in_load && (router_rt_dst == RB_W'(ROUTERS - 1));
    // The read address runs one entry ahead, so INIT already fetches dst 0.
    assign capture  = in_init || (in_load && !last_dst);

    always_comb begin
        rt_ops = '0;
        for (int r = 0; r < ROUTERS; r++) begin
            rt_ops[r*OP_W +: OP_W] = rt_rd_vld[r] ? OP_W'(OP_LOAD_RT)
                                                  : OP_W'(OP_NOP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_rd_addr     <= '0;
            router_rt_port <= '0;
            router_rt_dst  <= '0;
        end else if (capture) begin
            rt_rd_addr     <= rt_rd_addr + RB_W'(1);
            router_rt_port <= rt_rd_data;
            router_rt_dst  <= in_init ? '0 : router_rt_dst + RB_W'(1);
        end else begin
            rt_rd_addr     <= '0;
        end
    end

endmodule

// File: rtl/noc_sequencer.sv
// Top-level NoC fabric sequencer: INIT, routing-table load, then the
// STAGE/PH0/PH1 loop until the cycle budget. Optional: NOC_SEQ_DONE_WAIT_EN.
module noc_sequencer
    import noc_seq_pkg::*;
#(
    parameter  int ROUTERS = ROUTERS_DEF,
    parameter  int PORT_W  = PORT_W_DEF,
    parameter  int OP_W    = OP_W_DEF,
    parameter  int MC_W    = MC_W_DEF,
    localparam int RB_W    = $clog2(ROUTERS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [MC_W-1:0]           max_cycle,
    output logic [RB_W-1:0]           rt_rd_addr,
    input  logic [ROUTERS*PORT_W-1:0] rt_rd_data,
    input  logic [ROUTERS-1:0]        rt_rd_vld,
    input  logic [ROUTERS-1:0]        router_done,
    output logic [ROUTERS*OP_W-1:0]   router_op,
    output logic [ROUTERS*PORT_W-1:0] router_rt_port,
    output logic [RB_W-1:0]           router_rt_dst,
    output logic [MC_W-1:0]           in_cycle,
    output logic                      busy,
    output logic                      finished
);

    state_t                    state;
    logic [MC_W-1:0]           budget;
    logic [MC_W-1:0]           nxt_cycle;
    logic [ROUTERS*OP_W-1:0]   rt_ops;
    logic                      last_dst;

    function automatic logic [ROUTERS*OP_W-1:0] all_ops(input int op);
        all_ops = {ROUTERS{OP_W'(op)}};
    endfunction

    assign nxt_cycle = in_cycle + MC_W'(1);

`ifndef NOC_SEQ_DONE_WAIT_EN
    logic done_unused;
    assign done_unused = &router_done;
`endif

    noc_seq_rt_loader #(
        .ROUTERS (ROUTERS),
        .PORT_W  (PORT_W),
        .OP_W    (OP_W),
        .RB_W    (RB_W)
    ) u_loader (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_init        (state == S_INIT),
        .in_load        (state == S_LOAD_RT),
        .rt_rd_data     (rt_rd_data),
        .rt_rd_vld      (rt_rd_vld),
        .rt_rd_addr     (rt_rd_addr),
        .router_rt_port (router_rt_port),
        .router_rt_dst  (router_rt_dst),
        .rt_ops         (rt_ops),
        .last_dst       (last_dst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            router_op <= '0;
            budget    <= '0;
            in_cycle  <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        state     <= S_INIT;
                        router_op <= all_ops(OP_INIT);
                        budget    <= max_cycle;
                        in_cycle  <= '0;
                        busy      <= 1'b1;
                        finished  <= 1'b0;
                    end
                end
                S_INIT: begin
                    state     <= S_LOAD_RT;
                    router_op <= rt_ops;
                end
                S_LOAD_RT: begin
                    if (!last_dst) begin
                        router_op <= rt_ops;
                    end else if (budget == '0) begin
                        state     <= S_FINISH;
                        router_op <= all_ops(OP_NOP);
                        busy      <= 1'b0;
                        finished  <= 1'b1;
                    end else begin
                        state     <= S_STAGE;
                        router_op <= all_ops(OP_LOAD_STAGING);
                    end
                end
                S_STAGE: begin
                    state     <= S_PH0;
                    router_op <= all_ops(OP_PHASE0);
                end
                S_PH0: begin
                    state     <= S_PH1;
                    router_op <= all_ops(OP_PHASE1);
                end
                S_PH1: begin
                    in_cycle <= nxt_cycle;
                    if (nxt_cycle == budget) begin
                        state     <= S_FINISH;
                        router_op <= all_ops(OP_NOP);
                        busy      <= 1'b0;
                        finished  <= 1'b1;
                    end else begin
`ifdef NOC_SEQ_DONE_WAIT_EN
                        state     <= S_WAIT;
                        router_op <= all_ops(OP_NOP);
`else
                        state     <= S_STAGE;
                        router_op <= all_ops(OP_LOAD_STAGING);
`endif
                    end
                end
`ifdef NOC_SEQ_DONE_WAIT_EN
                S_WAIT: begin
                    if (&router_done) begin
                        state     <= S_STAGE;
                        router_op <= all_ops(OP_LOAD_STAGING);
                    end
                end
`endif
                default: begin
                    state     <= S_IDLE;
                    router_op <= all_ops(OP_NOP);
                    busy      <= 1'b0;
                    finished  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_sequencer.sv
// Directed bench for noc_sequencer with ROUTERS=4: per-cycle vector table
// plus hand-written reset and WAIT sequences.
module tb_noc_sequencer;

    localparam int R  = 4;
    localparam int PW = 3;
    localparam int OW = 3;
    localparam int MW = 16;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [MW-1:0]   max_cycle;
    logic [1:0]      rt_rd_addr;
    logic [R*PW-1:0] rt_rd_data;
    logic [R-1:0]    rt_rd_vld;
    logic [R-1:0]    router_done;
    logic [R*OW-1:0] router_op;
    logic [R*PW-1:0] router_rt_port;
    logic [1:0]      router_rt_dst;
    logic [MW-1:0]   in_cycle;
    logic            busy;
    logic            finished;

    int checks;
    int errors;

    logic            sparse;
    logic [R*PW-1:0] data_tab [4];

    noc_sequencer #(
        .ROUTERS (R),
        .PORT_W  (PW),
        .OP_W    (OW),
        .MC_W    (MW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .max_cycle      (max_cycle),
        .rt_rd_addr     (rt_rd_addr),
        .rt_rd_data     (rt_rd_data),
        .rt_rd_vld      (rt_rd_vld),
        .router_done    (router_done),
        .router_op      (router_op),
        .router_rt_port (router_rt_port),
        .router_rt_dst  (router_rt_dst),
        .in_cycle       (in_cycle),
        .busy           (busy),
        .finished       (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External routing table: entry 2 is sparse when requested.
    always_comb begin
        rt_rd_data = data_tab[rt_rd_addr];
        rt_rd_vld  = (sparse && rt_rd_addr == 2'd2) ? 4'b0101 : 4'b1111;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifndef NOC_SEQ_DONE_WAIT_EN
    typedef struct {
        logic            start;
        logic [MW-1:0]   mc;
        logic            sparse;
        logic [R*OW-1:0] op;
        logic            busy;
        logic            fin;
        logic [MW-1:0]   inc;
        logic [1:0]      addr;
        logic            chk_rt;
        logic [1:0]      dst;
        logic [R*PW-1:0] port;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic fill_vecs();
        // Run A: budget 2, full table, start pulsed during STAGE is ignored
        vecs[0]  = '{1'b1, 16'd2, 1'b0, 12'o1111, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[1]  = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 2'd0, 12'o0123};
        vecs[2]  = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd2, 1'b1, 2'd1, 12'o4567};
        vecs[3]  = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd3, 1'b1, 2'd2, 12'o7654};
        vecs[4]  = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd0, 1'b1, 2'd3, 12'o3210};
        vecs[5]  = '{1'b0, 16'd0, 1'b0, 12'o3333, 1'b1, 1'b0, 16'd0, 2'd0, 1'b1, 2'd3, 12'o3210};
        vecs[6]  = '{1'b1, 16'd7, 1'b0, 12'o4444, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[7]  = '{1'b0, 16'd0, 1'b0, 12'o5555, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[8]  = '{1'b0, 16'd0, 1'b0, 12'o3333, 1'b1, 1'b0, 16'd1, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[9]  = '{1'b0, 16'd0, 1'b0, 12'o4444, 1'b1, 1'b0, 16'd1, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[10] = '{1'b0, 16'd0, 1'b0, 12'o5555, 1'b1, 1'b0, 16'd1, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[11] = '{1'b0, 16'd0, 1'b0, 12'o0000, 1'b0, 1'b1, 16'd2, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[12] = '{1'b0, 16'd5, 1'b0, 12'o0000, 1'b0, 1'b1, 16'd2, 2'd0, 1'b0, 2'd0, 12'o0000};
        // Run B: budget 0, sparse entry at dst 2, straight to FINISH
        vecs[13] = '{1'b1, 16'd0, 1'b1, 12'o1111, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[14] = '{1'b0, 16'd0, 1'b1, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 2'd0, 12'o0123};
        vecs[15] = '{1'b0, 16'd0, 1'b1, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd2, 1'b1, 2'd1, 12'o4567};
        vecs[16] = '{1'b0, 16'd0, 1'b1, 12'o0202, 1'b1, 1'b0, 16'd0, 2'd3, 1'b1, 2'd2, 12'o7654};
        vecs[17] = '{1'b0, 16'd0, 1'b1, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd0, 1'b1, 2'd3, 12'o3210};
        vecs[18] = '{1'b0, 16'd0, 1'b1, 12'o0000, 1'b0, 1'b1, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        // Run C: restart from FINISH with budget 1
        vecs[19] = '{1'b1, 16'd1, 1'b0, 12'o1111, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[20] = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd1, 1'b1, 2'd0, 12'o0123};
        vecs[21] = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd2, 1'b0, 2'd0, 12'o0000};
        vecs[22] = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd3, 1'b0, 2'd0, 12'o0000};
        vecs[23] = '{1'b0, 16'd0, 1'b0, 12'o2222, 1'b1, 1'b0, 16'd0, 2'd0, 1'b1, 2'd3, 12'o3210};
        vecs[24] = '{1'b0, 16'd0, 1'b0, 12'o3333, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[25] = '{1'b0, 16'd0, 1'b0, 12'o4444, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[26] = '{1'b0, 16'd0, 1'b0, 12'o5555, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 2'd0, 12'o0000};
        vecs[27] = '{1'b0, 16'd0, 1'b0, 12'o0000, 1'b0, 1'b1, 16'd1, 2'd0, 1'b0, 2'd0, 12'o0000};
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        max_cycle   = '0;
        sparse      = 1'b0;
        router_done = 4'b1111;
        data_tab[0] = 12'o0123;
        data_tab[1] = 12'o4567;
        data_tab[2] = 12'o7654;
        data_tab[3] = 12'o3210;

        repeat (3) @(posedge clk);
        #1;
        chk("rst op",   router_op,      12'o0000);
        chk("rst busy", busy,           1'b0);
        chk("rst fin",  finished,       1'b0);
        chk("rst inc",  in_cycle,       16'd0);
        chk("rst addr", rt_rd_addr,     2'd0);
        chk("rst dst",  router_rt_dst,  2'd0);
        chk("rst port", router_rt_port, 12'o0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle op", router_op, 12'o0000);

`ifndef NOC_SEQ_DONE_WAIT_EN
        fill_vecs();
        for (int i = 0; i < NV; i++) begin
            start     = vecs[i].start;
            max_cycle = vecs[i].mc;
            sparse    = vecs[i].sparse;
            tick();
            chk($sformatf("v%0d op", i),   router_op,  vecs[i].op);
            chk($sformatf("v%0d busy", i), busy,       vecs[i].busy);
            chk($sformatf("v%0d fin", i),  finished,   vecs[i].fin);
            chk($sformatf("v%0d inc", i),  in_cycle,   vecs[i].inc);
            chk($sformatf("v%0d addr", i), rt_rd_addr, vecs[i].addr);
            if (vecs[i].chk_rt) begin
                chk($sformatf("v%0d dst", i),  router_rt_dst,  vecs[i].dst);
                chk($sformatf("v%0d port", i), router_rt_port, vecs[i].port);
            end
        end
        start  = 1'b0;
        sparse = 1'b0;
`endif

        // Asynchronous reset during PH0 of the first simulated cycle
        start     = 1'b1;
        max_cycle = 16'd2;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre-rst op", router_op, 12'o4444);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst op",   router_op,  12'o0000);
        chk("mid-rst inc",  in_cycle,   16'd0);
        chk("mid-rst busy", busy,       1'b0);
        chk("mid-rst fin",  finished,   1'b0);
        chk("mid-rst addr", rt_rd_addr, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start     = 1'b1;
        max_cycle = 16'd1;
        tick();
        start = 1'b0;
        chk("restart op",   router_op, 12'o1111);
        chk("restart busy", busy,      1'b1);
        repeat (8) tick();
        chk("restart fin", finished, 1'b1);
        chk("restart inc", in_cycle, 16'd1);

`ifdef NOC_SEQ_DONE_WAIT_EN
        // WAIT holds on router_done, then resumes with STAGE
        router_done = 4'b0111;
        start       = 1'b1;
        max_cycle   = 16'd2;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("w ph1 op", router_op, 12'o5555);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("w%0d op", k),   router_op, 12'o0000);
            chk($sformatf("w%0d inc", k),  in_cycle,  16'd1);
            chk($sformatf("w%0d busy", k), busy,      1'b1);
        end
        router_done = 4'b1111;
        tick();
        chk("w stage op", router_op, 12'o3333);
        repeat (3) tick();
        chk("w fin", finished, 1'b1);
        chk("w inc", in_cycle, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
